mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Two asynchronous (combinational) read ports, rs and rt, feed the ALU and the store-data path.
- One synchronous write port, rd, is driven by the writeback mux.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, width of the address ports; depth is 2**ADDR_W (32 entries).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- reg_write  input  1  write enable, sampled on rising clk.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rd_addr  input  ADDR_W  write address.
- write_data  input  DATA_W  data to write.
- rs_data  output  DATA_W  contents of register rs_addr.
- rt_data  output  DATA_W  contents of register rt_addr.

Behaviour:
- Storage: 2**ADDR_W registers, each DATA_W bits; entry 0 is never written and always reads 0.
- Reset:
  - While rst_n=0, all entries are 0 immediately, without waiting for a clk edge.
  - While rst_n=0, rs_data and rt_data read 0 and writes are ignored.
  - Reset asserted mid-operation discards any pending write.
  - After rst_n deasserts, the first write takes effect on the next rising clk.
- Write:
  - On rising clk, with rst_n=1, reg_write=1 and rd_addr!=0, the entry at rd_addr takes write_data.
  - reg_write=0 leaves all entries unchanged.
  - rd_addr=0 is silently discarded.
- Read:
  - rs_data = entry[rs_addr] and rt_data = entry[rt_addr], purely combinational with zero-cycle latency.
  - Outputs update within the same cycle when an address changes.
  - rs_addr=0 or rt_addr=0 yields 32'h0000_0000.
- Both read ports may address the same register and both return the identical value.
- Read-during-write to the same address (bypass disabled):
  - The read port returns the old contents until the rising edge.
  - After the edge it returns the new value; write-first visibility comes from the edge, not forwarding.
- No handshake; every cycle is independent. No X may propagate from uninitialised storage, because reset defines all entries.
- Address and data inputs are full-width; there are no out-of-range addresses.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: internal write-to-read forwarding.
  - When reg_write=1, rst_n=1, rd_addr!=0 and rd_addr equals rs_addr (or rt_addr), the matching read port combinationally outputs write_data in the same cycle, before the edge.
  - Reads of address 0 still return 0.
- Undefined: no forwarding; reads return stored contents only, as in the read-during-write rule above.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0, then release; set rs_addr=1, rt_addr=31.
  - Required: both outputs 0; after writing $1=abcd_1234 and then pulsing rst_n low between edges, rs_data returns 0 immediately.
- Sequential writes:
  - Stimulus: reg_write=1; write $1=abcd_1234, then $2=abcd_5678, then $1=abcd_abcd on successive edges; monitor rs_addr=1, rt_addr=2.
  - Required: after edge 1, rs=abcd_1234, rt=0; after edge 2, rt=abcd_5678; after edge 3, rs=abcd_abcd.
- Write disabled:
  - Stimulus: reg_write=0, rd_addr=1, write_data=abcd_1234 for two cycles.
  - Required: rs_data stays abcd_abcd and rt_data stays abcd_5678.
- Register zero:
  - Stimulus: reg_write=1, rd_addr=0, write_data=FFFF_FFFF; rs_addr=0, rt_addr=0.
  - Required: both read 0 before and after the edge.
- Read-during-write:
  - Stimulus: $5=1111_1111; next cycle write $5=2222_2222 with rs_addr=5.
  - Required without REGFILE_WRITE_BYPASS_EN: 1111_1111 before the edge, 2222_2222 after.
  - Required with REGFILE_WRITE_BYPASS_EN: 2222_2222 before the edge.
- Full sweep:
  - Stimulus: write entry i = i*32'h0101_0101 for i=1..31, then read all 31 through both ports.
  - Required: each read matches, and entry 31 = 1F1F_1F1F.

Source files
------------

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    // Writes to $0 are dropped here so entry 0 keeps its reset value forever.
    assign wr_en = reg_write && (rd_addr != '0);

    always_comb begin
        // NOTE: every element gets a default before the conditional update, so no latch is inferred.
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd_addr] = write_data;
        end
    end

    // NOTE: the array is reset asynchronously on purpose -- reads must never expose X, and
    // clearing must be visible at once while rst_n is low, not at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: state updates use <= so every entry samples regs_d from the same edge.
            regs_q <= regs_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (addr != '0) begin
`ifdef REGFILE_WRITE_BYPASS_EN
            if (rst_n && wr_en && (addr == rd_addr)) begin
                value = write_data;
            end else begin
                value = regs_q[addr];
            end
`else
            value = regs_q[addr];
`endif
        end
        return value;
    endfunction

    assign rs_data = read_port(rs_addr);
    assign rt_data = read_port(rt_addr);

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file; expectations are hand-computed constants
// plus the i*0101_0101 sweep pattern.
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    int total = 0;
    int bad   = 0;

    mips_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .rs_data    (rs_data),
        .rt_data    (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        rs_addr    = 5'd1;
        rt_addr    = 5'd31;
        rd_addr    = 5'd0;
        write_data = 32'h0;

        // Reset held across an edge
        #12;
        check("reset_rs", rs_data, 32'h0);
        check("reset_rt", rt_data, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_reset_rs", rs_data, 32'h0);
        check("post_reset_rt", rt_data, 32'h0);

        // Write $1, then pulse reset between edges with a write pending
        reg_write  = 1'b1;
        rd_addr    = 5'd1;
        write_data = 32'habcd_1234;
        tick();
        check("pre_pulse_rs", rs_data, 32'habcd_1234);
        rd_addr    = 5'd3;
        write_data = 32'h3333_3333;
        rt_addr    = 5'd3;
        rst_n      = 1'b0;
        #1;
        check("pulse_rs_immediate", rs_data, 32'h0);
        tick();
        check("pulse_write_ignored", rt_data, 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("release_before_edge", rt_data, 32'h0);
        tick();
        check("first_write_after_release", rt_data, 32'h3333_3333);

        // Sequential writes
        rs_addr    = 5'd1;
        rt_addr    = 5'd2;
        rd_addr    = 5'd1;
        write_data = 32'habcd_1234;
        tick();
        check("seq1_rs", rs_data, 32'habcd_1234);
        check("seq1_rt", rt_data, 32'h0);
        rd_addr    = 5'd2;
        write_data = 32'habcd_5678;
        tick();
        check("seq2_rs", rs_data, 32'habcd_1234);
        check("seq2_rt", rt_data, 32'habcd_5678);
        rd_addr    = 5'd1;
        write_data = 32'habcd_abcd;
        tick();
        check("seq3_rs", rs_data, 32'habcd_abcd);
        check("seq3_rt", rt_data, 32'habcd_5678);

        // Write disabled for two cycles
        reg_write  = 1'b0;
        rd_addr    = 5'd1;
        write_data = 32'habcd_1234;
        tick();
        tick();
        check("wdis_rs", rs_data, 32'habcd_abcd);
        check("wdis_rt", rt_data, 32'habcd_5678);

        // Both ports on the same register
        rt_addr = 5'd1;
        #1;
        check("same_reg_rt", rt_data, 32'habcd_abcd);

        // Register zero
        reg_write  = 1'b1;
        rd_addr    = 5'd0;
        write_data = 32'hffff_ffff;
        rs_addr    = 5'd0;
        rt_addr    = 5'd0;
        #1;
        check("zero_pre_rs", rs_data, 32'h0);
        check("zero_pre_rt", rt_data, 32'h0);
        tick();
        check("zero_post_rs", rs_data, 32'h0);
        check("zero_post_rt", rt_data, 32'h0);

        // Read-during-write on $5
        rd_addr    = 5'd5;
        write_data = 32'h1111_1111;
        tick();
        write_data = 32'h2222_2222;
        rs_addr    = 5'd5;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_before_edge", rs_data, 32'h2222_2222);
`else
        check("rdw_before_edge", rs_data, 32'h1111_1111);
`endif
        check("rdw_rt_zero", rt_data, 32'h0);
        tick();
        check("rdw_after_edge", rs_data, 32'h2222_2222);

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            rd_addr    = 5'(i);
            write_data = 32'(i) * 32'h0101_0101;
            tick();
        end
        reg_write = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(32 - i);
            #1;
            check($sformatf("sweep_rs[%0d]", i), rs_data, 32'(i) * 32'h0101_0101);
            check($sformatf("sweep_rt[%0d]", 32 - i), rt_data, 32'(32 - i) * 32'h0101_0101);
        end
        rs_addr = 5'd31;
        rt_addr = 5'd0;
        #1;
        check("sweep_entry31", rs_data, 32'h1f1f_1f1f);
        check("sweep_zero", rt_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
